// File: rtl/load_pkg.sv
// Shared load-path definitions: funct3 width codes, FSM states, error codes.
// No logic, so no latency or backpressure of its own.
// Legality helpers keep the decode rules in one place for the top.
package load_pkg;

    localparam logic [2:0] W_LB  = 3'b000;
    localparam logic [2:0] W_LH  = 3'b001;
    localparam logic [2:0] W_LW  = 3'b010;
    localparam logic [2:0] W_LBU = 3'b100;
    localparam logic [2:0] W_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_WIDTH    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic width_legal(input logic [2:0] w);
        return (w == W_LB) || (w == W_LH) || (w == W_LW) ||
               (w == W_LBU) || (w == W_LHU);
    endfunction

    // Only meaningful for legal widths; bit 1:0 of funct3 encodes the size.
    function automatic logic misaligned(input logic [1:0] off, input logic [2:0] w);
        return ((w[1:0] == 2'b01) && off[0]) || ((w[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword/word from a read word and extends it.
// Purely combinational, zero latency.
// No handshake; the caller holds inputs stable for as long as the output is needed.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  width_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = offset_i[1] ? word_i[31:16] : word_i[15:0];
        // funct3 bit 2 marks the unsigned variants
        sext    = ~width_i[2];
        case (width_i[1:0])
            2'b00:   data_o = {{24{sext & byte_v[7]}}, byte_v};
            2'b01:   data_o = {{16{sext & half_v[15]}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load path: accept request, issue one aligned read, wait, extract and extend.
// Latency 2 cycles zero-wait, +1 per WAIT cycle; errors return in 1 cycle.
// One load in flight; req_ready only in IDLE, result held until wb_ready.
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_width,
    input  logic [4:0]  req_rd,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    width_q, width_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ext_data;

    load_extract u_extract (
        .word_i   (word_q),
        .offset_i (addr_q[1:0]),
        .width_i  (width_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            width_q <= '0;
            rd_q    <= '0;
            word_q  <= '0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            rd_q    <= rd_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        width_d = width_q;
        rd_d    = rd_q;
        word_d  = word_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        mem_ren = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    width_d = req_width;
                    rd_d    = req_rd;
                    if (!width_legal(req_width)) begin
                        err_d   = ERR_WIDTH;
                        state_d = S_RESP;
                    end else if (misaligned(req_addr[1:0], req_width)) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_ren = 1'b1;
                if (mem_rvalid) begin
                    word_d  = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Data arriving on the final counted cycle beats the timeout.
                if (mem_rvalid) begin
                    word_d  = mem_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign wb_valid  = (state_q == S_RESP);
    assign wb_data   = (wb_valid && err_q == ERR_NONE) ? ext_data : 32'h0;
    assign wb_rd     = wb_valid ? rd_q : 5'h0;
    assign wb_err    = wb_valid ? err_q : ERR_NONE;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a result scoreboard and cycle-exact latency checks.
module tb_load_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_width;
    logic [4:0]  req_rd;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_width  (req_width),
        .req_rd     (req_rd),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_err     (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // waits: -1 = memory never answers, else number of WAIT cycles before rvalid.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] width,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input int rdy_delay, input logic [31:0] exp_data,
                           input logic [1:0] exp_err, input int exp_lat);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   got;
        bit   saw_ren;
        e.data = exp_data;
        e.rd   = rd;
        e.err  = exp_err;
        sb.push_back(e);

        @(negedge clk);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_width = width;
        req_rd    = rd;
        mem_rdata = rdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        cyc     = 1;
        got     = 1'b0;
        saw_ren = 1'b0;
        while (cyc <= 40 && !got) begin
            mem_rvalid = (waits >= 0) && (cyc == 1 + waits);
            @(negedge clk);
            if (mem_ren) begin
                saw_ren = 1'b1;
                chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            end
            if (wb_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        mem_rvalid = 1'b0;
        chk({tag, "_wb_valid_seen"}, {31'b0, got}, 32'd1);
        got_e = sb.pop_front();
        if (got) begin
            chk({tag, "_latency"}, cyc, exp_lat);
            chk({tag, "_data"}, wb_data, got_e.data);
            chk({tag, "_rd"}, {27'b0, wb_rd}, {27'b0, got_e.rd});
            chk({tag, "_err"}, {30'b0, wb_err}, {30'b0, got_e.err});
            chk({tag, "_mem_ren_seen"}, {31'b0, saw_ren}, {31'b0, (exp_lat > 1)});
            for (int k = 0; k < rdy_delay; k++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk({tag, "_hold_valid"}, {31'b0, wb_valid}, 32'd1);
                chk({tag, "_hold_data"}, wb_data, got_e.data);
                chk({tag, "_hold_no_accept"}, {31'b0, req_ready}, 32'd0);
            end
            wb_ready = 1'b1;
            @(posedge clk);
            #1;
            wb_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_valid_drop"}, {31'b0, wb_valid}, 32'd0);
            chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_width  = '0;
        req_rd     = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        wb_ready   = 1'b0;

        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rst_wb_err", {30'b0, wb_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load("lbu_b3",  32'h0000_1003, 3'b100, 5'd1, 32'h80FF_1234, 0, 0, 32'h0000_0080, 2'b00, 2);
        do_load("lb_b3",   32'h0000_1003, 3'b000, 5'd2, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 2'b00, 2);
        do_load("lh_h1",   32'h0000_1002, 3'b001, 5'd3, 32'h80FF_1234, 0, 0, 32'hFFFF_80FF, 2'b00, 2);
        do_load("lhu_h1",  32'h0000_1002, 3'b101, 5'd4, 32'h80FF_1234, 0, 0, 32'h0000_80FF, 2'b00, 2);
        do_load("lb_b1",   32'h0000_1001, 3'b000, 5'd5, 32'h80FF_1234, 1, 0, 32'h0000_0012, 2'b00, 3);
        do_load("lbu_b2",  32'h0000_1002, 3'b100, 5'd6, 32'h80FF_1234, 0, 0, 32'h0000_00FF, 2'b00, 2);
        do_load("lh_h0",   32'h0000_1000, 3'b001, 5'd7, 32'h1234_8001, 0, 0, 32'hFFFF_8001, 2'b00, 2);
        do_load("lw_wait", 32'h0000_2000, 3'b010, 5'd8, 32'hDEAD_BEEF, 3, 2, 32'hDEAD_BEEF, 2'b00, 5);
        do_load("lh_mis",  32'h0000_1001, 3'b001, 5'd9, 32'h80FF_1234, 0, 0, 32'h0, 2'b01, 1);
        do_load("lw_mis",  32'h0000_1002, 3'b010, 5'd10, 32'h80FF_1234, 0, 0, 32'h0, 2'b01, 1);
        do_load("w011",    32'h0000_1001, 3'b011, 5'd11, 32'h80FF_1234, 0, 0, 32'h0, 2'b10, 1);
        do_load("w110",    32'h0000_1000, 3'b110, 5'd12, 32'h80FF_1234, 0, 0, 32'h0, 2'b10, 1);
        // Response on the last counted WAIT cycle must win over the timeout.
        do_load("lw_edge", 32'h0000_3000, 3'b010, 5'd13, 32'h0BAD_F00D, TO, 0, 32'h0BAD_F00D, 2'b00, TO + 2);
        do_load("timeout", 32'h0000_4000, 3'b010, 5'd14, 32'hAAAA_5555, -1, 1, 32'h0, 2'b11, TO + 2);

        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        chk("late_rvalid_no_wb", {31'b0, wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_no_wb2", {31'b0, wb_valid}, 32'd0);
        chk("late_rvalid_idle", {31'b0, req_ready}, 32'd1);
        do_load("after_to", 32'h0000_5004, 3'b010, 5'd15, 32'hCAFE_0001, 1, 0, 32'hCAFE_0001, 2'b00, 3);

        // Abandon a load mid-WAIT with an asynchronous reset.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_6000;
        req_width = 3'b010;
        req_rd    = 5'd21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_mem_ren", {31'b0, mem_ren}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("arst_wb_err", {30'b0, wb_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        chk("arst_late_no_wb", {31'b0, wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_quiet", {31'b0, wb_valid}, 32'd0);
        end
        do_load("after_rst", 32'h0000_7003, 3'b000, 5'd22, 32'h7F00_0000, 0, 0, 32'h0000_007F, 2'b00, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_unit.md
# load_unit

Sequential load path for the single-issue core's data-memory port, the read-side counterpart of the store-data generator. Accepts a load request (address, funct3 width, destination tag) from execute, issues a word-aligned read to data memory, waits a variable number of cycles for the response, and extracts the addressed byte, halfword or word. It then sign- or zero-extends the result and presents it to writeback under a valid/ready handshake. Misaligned or illegal-width loads, and memory timeouts, are reported as errors instead of being sent to memory or returned as data.

## Interface
- Reset: one clock; reset is asynchronous and active-low.
- TIMEOUT, default 16: number of WAIT cycles without `mem_rvalid` before a timeout error; legal range 1..255.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute presents a load.
- req_ready  out  1  unit can accept a load; high only in IDLE.
- req_addr  in  32  byte address.
- req_width  in  3  instruction[14:12]: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_rd  in  5  destination register tag, returned unchanged.
- mem_ren  out  1  read strobe to data memory.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word, little-endian; byte n on bits [8n+7:8n].
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts result.
- wb_data  out  32  extended load data; 0 when wb_err is nonzero.
- wb_rd  out  5  captured req_rd.
- wb_err  out  2  00 ok, 01 misaligned, 10 illegal width, 11 timeout.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture addr, width and rd.
  - Illegal width (011, 110, 111): go to RESP with err=10.
  - Otherwise, misaligned (halfword with addr[0]=1, or word with addr[1:0]≠00): go to RESP with err=01.
  - Otherwise: go to REQ.
  - Illegal width takes priority over misaligned.
- REQ: mem_ren=1 for exactly this cycle, mem_addr driven. mem_rvalid=1 in this same cycle → capture data, go to RESP. Otherwise go to WAIT and clear the timeout counter.
- WAIT: mem_ren=0, mem_addr held. Timeout counter increments each cycle.
  - mem_rvalid=1 → capture data, go to RESP.
  - Counter reaches TIMEOUT → go to RESP with err=11.
  - If both happen in the same cycle, mem_rvalid wins.
- RESP: wb_valid=1 and wb_data, wb_rd, wb_err held stable. On wb_ready → IDLE.
- mem_rvalid is ignored in IDLE and RESP; a late response after a timeout is dropped.
- Extraction from the captured word w, with offset o = addr[1:0]:
  - Byte: w[8o+7:8o].
  - Halfword: w[15:0] if addr[1]=0, else w[31:16].
  - Word: w.
  - LB and LH sign-extend from bit 7 or bit 15; LBU and LHU zero-extend.
- Extraction is combinational from the registered word and captured control. wb_data is stable for the whole time the unit is in RESP.

## Timing
- Reset (async assert): state=IDLE. Outputs: req_ready=1, mem_ren=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=00. Counter=0.
- Reset in the middle of a transaction abandons it. No writeback is produced, and a response arriving after reset is ignored.
- Accept at edge 0 → mem_ren high in cycle 1.
- Zero-wait memory (mem_rvalid during REQ): wb_valid in cycle 2. Best-case load-to-writeback latency is 2 cycles.
- Each WAIT cycle adds 1 cycle of latency.
- Error path (misaligned or illegal width): wb_valid in cycle 1; mem_ren never asserted.
- Timeout: wb_valid TIMEOUT+2 cycles after accept.
- Throughput: one load in flight. The next accept comes no earlier than the cycle after the wb handshake; the unit does not accept in the same cycle it completes.
- wb_valid never drops without wb_ready, and its payload never changes while it is high.

## Structure
- Package load_pkg holds:
  - width codes (LB, LH, LW, LBU, LHU);
  - the state enum;
  - error codes ERR_NONE, ERR_MISALIGN, ERR_WIDTH, ERR_TIMEOUT.
- Sub-module load_extract: purely combinational (word, offset, width) → extended 32-bit data. Unit-testable on its own.
- Top: FSM, capture registers, timeout counter sized as $clog2(TIMEOUT+1).

## Test plan
- LBU addr 0x1003, mem_rdata 0x80FF_1234, zero wait → mem_addr 0x1000; wb_data 0x0000_0080, err 00; wb_valid in cycle 2.
- LB addr 0x1003, same data → wb_data 0xFFFF_FF80. LH addr 0x1002 → 0xFFFF_80FF. LHU addr 0x1002 → 0x0000_80FF.
- LW addr 0x2000, mem_rvalid after 3 WAIT cycles with data 0xDEAD_BEEF, and wb_ready held low for 2 cycles → wb_data stays 0xDEAD_BEEF. No new accept until the handshake completes.
- LH addr 0x1001 → err 01 in cycle 1, mem_ren never high. Width 011 at addr 0x1001 → err 10.
- TIMEOUT=4, no mem_rvalid → err 11 and wb_data 0 at cycle 6. A mem_rvalid arriving afterwards is dropped, and the next load completes normally.
- rst_n pulsed low during WAIT → all outputs at reset values immediately. A mem_rvalid one cycle after release produces no wb_valid.
